// File: rtl/nanorv32_lsu.sv
// nanorv32 load/store unit: turns one byte/half/word access into a word-aligned
// data-memory handshake and returns aligned, extended load data with done/err.
module nanorv32_lsu #(
  parameter int NANORV32_ADDR_W = 32,
  parameter int NANORV32_DATA_W = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic                       lsu_write,
  input  logic [1:0]                 lsu_size,
  input  logic                       lsu_unsigned,
  input  logic [NANORV32_ADDR_W-1:0] lsu_addr,
  input  logic [NANORV32_DATA_W-1:0] lsu_wdata,
  output logic                       lsu_done,
  output logic                       lsu_err,
  output logic [NANORV32_DATA_W-1:0] lsu_rdata,
  output logic [NANORV32_ADDR_W-1:0] cpu_datamem_addr,
  output logic [NANORV32_DATA_W-1:0] cpu_datamem_wdata,
  output logic [3:0]                 cpu_datamem_bytesel,
  output logic                       cpu_datamem_req,
  input  logic [NANORV32_DATA_W-1:0] datamem_cpu_rdata,
  input  logic                       datamem_cpu_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q;
  logic                         write_q;
  logic [1:0]                   size_q;
  logic                         unsigned_q;
  logic [1:0]                   off_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         ready_q;
  logic                         done_q;
  logic                         err_q;
  logic [NANORV32_DATA_W-1:0]   rdata_q;
  logic                         req_q;
  logic [NANORV32_ADDR_W-1:0]   bus_addr_q;
  logic [NANORV32_DATA_W-1:0]   bus_wdata_q;
  logic [3:0]                   bus_bytesel_q;
  logic                         expired;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : 32'(b);
      2'b01:   return uns ? {16'd0, h} : 32'(h);
      default: return rd;
    endcase
  endfunction

  // Ack in the expiry cycle is checked first, so it wins over the timeout.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      off_q         <= 2'b00;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      req_q         <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_bytesel_q <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lsu_valid) begin
            write_q    <= lsu_write;
            size_q     <= lsu_size;
            unsigned_q <= lsu_unsigned;
            off_q      <= lsu_addr[1:0];
            ready_q    <= 1'b0;
            if (is_misaligned(lsu_size, lsu_addr[1:0])) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q       <= S_WAIT;
              req_q         <= 1'b1;
              bus_addr_q    <= {lsu_addr[NANORV32_ADDR_W-1:2], 2'b00};
              bus_bytesel_q <= lane_sel(lsu_size, lsu_addr[1:0]);
              bus_wdata_q   <= lsu_write ? replicate(lsu_size, lsu_wdata) : '0;
            end
          end
        end
        S_WAIT: begin
          if (datamem_cpu_ack || expired) begin
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            err_q         <= !datamem_cpu_ack;
            rdata_q       <= (datamem_cpu_ack && !write_q)
                             ? load_align(size_q, unsigned_q, off_q, datamem_cpu_rdata) : '0;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_bytesel_q <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign lsu_ready           = ready_q;
  assign lsu_done            = done_q;
  assign lsu_err             = err_q;
  assign lsu_rdata           = rdata_q;
  assign cpu_datamem_req     = req_q;
  assign cpu_datamem_addr    = bus_addr_q;
  assign cpu_datamem_wdata   = bus_wdata_q;
  assign cpu_datamem_bytesel = bus_bytesel_q;

endmodule

// File: tb/tb_nanorv32_lsu.sv
// Randomized bench for nanorv32_lsu against a transaction-level reference model.
module tb_nanorv32_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_ready, lsu_write, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_done, lsu_err;
  logic [31:0] cpu_datamem_addr, cpu_datamem_wdata;
  logic [3:0]  cpu_datamem_bytesel;
  logic        cpu_datamem_req;
  logic [31:0] datamem_cpu_rdata;
  logic        datamem_cpu_ack;

  int errs = 0;
  int checks = 0;

  int          last_lat, last_reqcnt;
  logic        last_err;
  logic [31:0] last_rdata, last_bus_addr, last_bus_wdata;
  logic [3:0]  last_bytesel;

  nanorv32_lsu #(.NANORV32_ADDR_W(32), .NANORV32_DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_write(lsu_write),
    .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .cpu_datamem_addr(cpu_datamem_addr), .cpu_datamem_wdata(cpu_datamem_wdata),
    .cpu_datamem_bytesel(cpu_datamem_bytesel), .cpu_datamem_req(cpu_datamem_req),
    .datamem_cpu_rdata(datamem_cpu_rdata), .datamem_cpu_ack(datamem_cpu_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_bytesel(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // Starts and ends at a falling edge with the LSU idle. d = wait cycles before ack; d >= 16 never acks.
  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rd);
    bit          mis, found;
    int          exp_req, exp_lat, reqcnt;
    logic        exp_err;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_bs;
    mis     = ref_misaligned(sz, a);
    exp_req = mis ? 0 : ((d < 16) ? d + 1 : 16);
    exp_err = mis || d >= 16;
    exp_lat = mis ? 1 : exp_req + 1;
    exp_rd  = (exp_err || wr) ? 32'd0 : ref_load(sz, uns, a, rd);
    exp_bs  = ref_bytesel(sz, a);
    exp_wd  = wr ? ref_wdata(sz, wd) : 32'd0;
    reqcnt  = 0;
    found   = 0;
    last_bus_addr = 32'd0; last_bus_wdata = 32'd0; last_bytesel = 4'd0;
    check("ready_idle", lsu_ready, 1);
    lsu_valid = 1; lsu_write = wr; lsu_size = sz; lsu_unsigned = uns;
    lsu_addr = a; lsu_wdata = wd;
    @(posedge clk); #1;
    lsu_valid = 0; datamem_cpu_ack = 0;
    lsu_write = 1'($urandom); lsu_size = 2'($urandom); lsu_unsigned = 1'($urandom);
    lsu_addr = $urandom; lsu_wdata = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cpu_datamem_req) begin
        reqcnt++;
        check("bus_addr", cpu_datamem_addr, a & ~32'd3);
        check("bus_bytesel", cpu_datamem_bytesel, exp_bs);
        check("bus_wdata", cpu_datamem_wdata, exp_wd);
        last_bus_addr = cpu_datamem_addr; last_bus_wdata = cpu_datamem_wdata;
        last_bytesel = cpu_datamem_bytesel;
      end
      if (lsu_done) begin
        found = 1;
        check("done_latency", cyc, exp_lat);
        check("req_cycles", reqcnt, exp_req);
        check("err", lsu_err, exp_err);
        check("rdata", lsu_rdata, exp_rd);
        last_lat = cyc; last_reqcnt = reqcnt; last_err = lsu_err; last_rdata = lsu_rdata;
        break;
      end
      if (cpu_datamem_req && reqcnt == d + 1) begin
        datamem_cpu_ack = 1; datamem_cpu_rdata = rd;
      end else begin
        datamem_cpu_ack = 0; datamem_cpu_rdata = $urandom;
      end
      lsu_valid = 1'($urandom);
    end
    if (!found) check("done_seen", 0, 1);
    datamem_cpu_ack = 0;
    @(negedge clk);
    check("done_one_cycle", lsu_done, 0);
    check("ready_after", lsu_ready, 1);
    lsu_valid = 0;
    datamem_cpu_ack = 1'($urandom);
    datamem_cpu_rdata = $urandom;
  endtask

  initial begin
    int dones;
    rst = 1; lsu_valid = 0; lsu_write = 0; lsu_size = 0; lsu_unsigned = 0;
    lsu_addr = 0; lsu_wdata = 0; datamem_cpu_rdata = 0; datamem_cpu_ack = 0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", lsu_ready, 1);
    check("rst_req", cpu_datamem_req, 0);
    check("rst_done", lsu_done, 0);
    check("rst_err", lsu_err, 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_bytesel", cpu_datamem_bytesel, 0);
    rst = 0;
    @(negedge clk);

    do_txn(0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h80AABBCC);
    check("lb_signed_rdata", last_rdata, 32'hFFFFFF80);
    check("lb_bus_addr", last_bus_addr, 32'h100);
    check("lb_bytesel", last_bytesel, 4'b1000);
    check("lb_latency", last_lat, 2);
    do_txn(0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h80AABBCC);
    check("lbu_rdata", last_rdata, 32'h00000080);

    do_txn(1, 2'd1, 0, 32'h22, 32'h1234ABCD, 3, 32'hDEADBEEF);
    check("sh_req_cycles", last_reqcnt, 4);
    check("sh_bytesel", last_bytesel, 4'b1100);
    check("sh_wdata", last_bus_wdata, 32'hABCDABCD);
    check("sh_rdata", last_rdata, 32'h0);
    check("sh_err", last_err, 0);

    do_txn(0, 2'd2, 0, 32'h41, 32'h0, 0, 32'h12345678);
    check("mis_word_err", last_err, 1);
    check("mis_word_req", last_reqcnt, 0);
    check("mis_word_lat", last_lat, 1);
    do_txn(0, 2'd3, 0, 32'h0, 32'h0, 0, 32'h12345678);
    check("rsvd_err", last_err, 1);
    check("rsvd_req", last_reqcnt, 0);

    do_txn(0, 2'd2, 0, 32'h80, 32'h0, 99, 32'h0);
    check("to_req_cycles", last_reqcnt, 16);
    check("to_err", last_err, 1);
    do_txn(0, 2'd2, 0, 32'h80, 32'h0, 15, 32'hCAFEF00D);
    check("ack_at_expiry_err", last_err, 0);
    check("ack_at_expiry_rdata", last_rdata, 32'hCAFEF00D);

    // Reset in the middle of a bus request.
    datamem_cpu_ack = 0;
    lsu_valid = 1; lsu_write = 0; lsu_size = 2'd2; lsu_addr = 32'h10;
    @(posedge clk); #1; lsu_valid = 0;
    @(negedge clk); @(negedge clk);
    check("pre_rst_req", cpu_datamem_req, 1);
    rst = 1; #1;
    check("midrst_req", cpu_datamem_req, 0);
    check("midrst_done", lsu_done, 0);
    check("midrst_err", lsu_err, 0);
    check("midrst_ready", lsu_ready, 1);
    #2 rst = 0;
    dones = 0;
    datamem_cpu_ack = 1; datamem_cpu_rdata = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lsu_done) dones++;
    end
    datamem_cpu_ack = 0;
    check("late_ack_no_done", dones, 0);

    do_txn(0, 2'd2, 0, 32'h0, 32'h0, 0, 32'h11112222);
    check("b2b0_rdata", last_rdata, 32'h11112222);
    do_txn(0, 2'd2, 0, 32'h4, 32'h0, 0, 32'h33334444);
    check("b2b1_rdata", last_rdata, 32'h33334444);
    check("b2b1_latency", last_lat, 2);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int d;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'd3 | (32'($urandom_range(0, 1)) << 1);
      d = $urandom_range(0, 19);
      if (d >= 17) d = 99;
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, d, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/nanorv32_lsu.md
Name: nanorv32_lsu

Overview:
- Load/store unit downstream of the nanorv32 execute stage; sits between the CPU's data-access request and the data memory bus.
- Takes one byte/half/word access per transaction and drives the data memory handshake with word-aligned address, byte lanes and replicated write data.
- Returns aligned, sign/zero-extended load data plus a completion/error pulse.
- Detects misaligned accesses and bus timeouts.

Parameters:
- NANORV32_ADDR_W, 32, address width
- NANORV32_DATA_W, 32, data width (fixed 32; other values unsupported)
- TIMEOUT_CYCLES, 16, cycles in WAIT without ack before error abort; 0 disables timeout

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- lsu_valid  in  1  request valid from execute stage
- lsu_ready  out  1  high only in IDLE; request accepted when lsu_valid & lsu_ready
- lsu_write  in  1  1=store, 0=load
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- lsu_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, LSBs significant
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  qualifies lsu_done: misaligned or timeout
- lsu_rdata  out  32  load result, valid with lsu_done on a good load, else 0
- cpu_datamem_addr  out  32  word-aligned address {lsu_addr[31:2],2'b00}
- cpu_datamem_wdata  out  32  lane-replicated store data
- cpu_datamem_bytesel  out  4  active byte lanes
- cpu_datamem_req  out  1  bus request
- datamem_cpu_rdata  in  32  read data, valid with ack
- datamem_cpu_ack  in  1  bus acknowledge

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except lsu_ready=1; timeout counter 0.
- Reset mid-transaction: req drops at once; the transaction is lost and no lsu_done is issued.
- States:
  - IDLE: on accept, latch write, size, unsigned, addr[1:0] and wdata.
    - Misaligned or reserved size: go to DONE with err=1; the bus is never touched.
    - Otherwise: go to WAIT with req=1 from the next cycle.
  - WAIT: req, addr, wdata and bytesel held stable.
    - On ack: register the load result; go to DONE; req=0 next cycle.
    - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with err=1, req=0.
    - Ack in the same cycle as expiry: ack wins (normal completion).
  - DONE: lsu_done=1 for exactly one cycle; then IDLE.
- Minimum latency: accept T0, req T1, ack T1, lsu_done T2. Back-to-back throughput: one access per 3 cycles.
- Misaligned:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - size 11 (reserved)
- Bytesel:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
  - Reads drive bytesel the same way.
- Wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - Loads drive 0.
- Load data:
  - Select lane from rdata by latched addr[1:0] (byte) or addr[1] (half).
  - Extend per lsu_unsigned; word passes through.
- Store completion: lsu_rdata=0.
- Timeout counter: counts only in WAIT, cleared on leaving WAIT; width clog2(TIMEOUT_CYCLES)+1.
- Ignored inputs:
  - Ack outside WAIT.
  - lsu_valid while lsu_ready=0; it is not queued, and the requester must hold it.
- Inputs after accept do not affect the transaction.

Test Plan:
- Load byte, addr 0x103, signed, rdata 0x80AABBCC, ack in first req cycle -> bus addr 0x100, bytesel 1000, lsu_done at T2 with rdata 0xFFFFFF80, err 0; repeat unsigned -> 0x00000080.
- Store half, addr 0x22, wdata 0x1234ABCD, ack after 3 wait cycles -> req high 4 cycles, bytesel 1100, wdata 0xABCDABCD, stable throughout; lsu_done, err 0, rdata 0.
- Word load addr 0x41 -> no req ever, lsu_done at T1 with err 1; size 11 at addr 0 -> same.
- No ack, TIMEOUT_CYCLES=16 -> req high exactly 16 cycles then drops, lsu_done err 1; variant with ack on the 16th cycle -> normal completion, err 0.
- rst pulsed while req high in WAIT -> req, done and err drop immediately, lsu_ready=1; a late ack after reset produces no lsu_done.
- Two back-to-back word loads at addrs 0x0 and 0x4 with immediate ack -> accepts at T0 and T3, two done pulses, correct rdata each.
